// File: rtl/ex_muldiv.sv
// Iterative MIPS-style HI/LO multiply/divide unit (MULT, MULTU, DIV, DIVU, MTHI, MTLO).
// Latency: start to done = 34 cycles (1 latch, 32 iterations, 1 sign fix-up).
// Backpressure: stall holds the pipeline while busy; start while busy is ignored.
module ex_muldiv (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        stall,
    output logic        done
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [1:0]  op_q, op_d;
    logic        sa_q, sa_d;     // operand A was negative (signed ops only)
    logic        sb_q, sb_d;     // operand B was negative (signed ops only)
    logic [31:0] a_q, a_d;       // |multiplicand|
    logic [31:0] b_q, b_d;       // |multiplier| or |divisor|
    logic [63:0] acc_q, acc_d;   // product accumulator; quotient/dividend in [31:0] for divide
    logic [31:0] rem_q, rem_d;   // partial remainder
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;

    logic        is_signed;
    logic [32:0] rem_sh;
    logic [32:0] msum;
    logic [63:0] prod;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;

    // Next-state logic: operand capture, one iteration per RUN cycle, sign fix-up in FIX
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        sa_d      = sa_q;
        sb_d      = sb_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        rem_d     = rem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        is_signed = ~op[0];
        rem_sh    = {rem_q, acc_q[31]};
        msum      = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, a_q} : 33'd0);
        prod      = (sa_q ^ sb_q) ? (64'd0 - acc_q) : acc_q;
        quo_fix   = (sa_q ^ sb_q) ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
        rem_fix   = sa_q ? (32'd0 - rem_q) : rem_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d    = op;
                    sa_d    = is_signed & rs_val[31];
                    sb_d    = is_signed & rt_val[31];
                    a_d     = (is_signed & rs_val[31]) ? (32'd0 - rs_val) : rs_val;
                    b_d     = (is_signed & rt_val[31]) ? (32'd0 - rt_val) : rt_val;
                    cnt_d   = 6'd0;
                    rem_d   = 32'd0;
                    // Divide shifts the dividend out of acc[31:0]; multiply shifts the multiplier out
                    acc_d   = {32'd0, op[1] ? a_d : b_d};
                    state_d = S_RUN;
                end else begin
                    if (hi_we) hi_d = wdata;
                    if (lo_we) lo_d = wdata;
                end
            end
            S_RUN: begin
                cnt_d = cnt_q + 6'd1;
                if (op_q[1]) begin
                    // Restoring step; the kept remainder is always below the divisor so 32 bits suffice
                    if (rem_sh >= {1'b0, b_q}) begin
                        rem_d        = rem_sh[31:0] - b_q;
                        acc_d[31:0]  = {acc_q[30:0], 1'b1};
                    end else begin
                        rem_d        = rem_sh[31:0];
                        acc_d[31:0]  = {acc_q[30:0], 1'b0};
                    end
                end else begin
                    acc_d = {msum, acc_q[31:1]};
                end
                if (cnt_q == 6'd31) state_d = S_FIX;
            end
            S_FIX: begin
                if (op_q[1]) begin
                    // Zero divisor leaves quotient all ones and remainder = |A|, so hi restores rs_val
                    lo_d = (b_q == 32'd0) ? 32'hFFFF_FFFF : quo_fix;
                    hi_d = rem_fix;
                end else begin
                    hi_d = prod[63:32];
                    lo_d = prod[31:0];
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers with synchronous reset taking priority over all requests
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 6'd0;
            op_q    <= 2'd0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            acc_q   <= 64'd0;
            rem_q   <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    // Outputs: stall also covers the accepting cycle so ID/EX holds the operands at T0
    always_comb begin
        hi    = hi_q;
        lo    = lo_q;
        done  = done_q;
        busy  = (state_q != S_IDLE);
        stall = (state_q != S_IDLE) | (start & (state_q == S_IDLE));
    end

endmodule

// File: tb/tb_ex_muldiv.sv
module tb_ex_muldiv;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [31:0] rs_val = 32'd0;
    logic [31:0] rt_val = 32'd0;
    logic        hi_we = 1'b0;
    logic        lo_we = 1'b0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] hi, lo;
    logic        busy, stall, done;

    int n_tests = 0;
    int n_fail  = 0;

    ex_muldiv dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .rs_val(rs_val), .rt_val(rt_val), .hi_we(hi_we), .lo_we(lo_we),
        .wdata(wdata), .hi(hi), .lo(lo), .busy(busy), .stall(stall), .done(done)
    );

    always #5 clk = ~clk;

    // Reference: {hi,lo} from plain integer arithmetic
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        res = 64'd0;
        case (o)
            2'd0: res = sa * sb;
            2'd1: res = {32'd0, a} * {32'd0, b};
            default: begin
                if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
                else if (o == 2'd2) begin
                    q = sa / sb;
                    r = sa % sb;
                    res = {r[31:0], q[31:0]};
                end else res = {a % b, a / b};
            end
        endcase
        return res;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    // Drives one operation; cycle 0 is the start cycle, cycle n's inputs are sampled at edge Tn
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input bit chain, input bit we_at_start, input int we_cyc, input int st_cyc,
                          output logic [31:0] rhi, output logic [31:0] rlo, output logic [31:0] pre_hi,
                          output int done_cyc, output int busy_cnt, output logic stall0);
        done_cyc = -1; busy_cnt = 0; rhi = '0; rlo = '0; pre_hi = '0;
        if (!chain) @(negedge clk);
        start = 1'b1; op = o; rs_val = a; rt_val = b;
        if (we_at_start) begin hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h5555_5555; end
        #1 stall0 = stall;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
            rs_val = $urandom; rt_val = $urandom; op = 2'($urandom);
            if (busy) busy_cnt++;
            if (n == 33) pre_hi = hi;
            if (done) begin done_cyc = n; rhi = hi; rlo = lo; break; end
            if (n == we_cyc) begin hi_we = 1'b1; wdata = 32'hDEAD_BEEF; end
            if (n == st_cyc) begin start = 1'b1; op = 2'd3; end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hFFFF_0000;
        repeat (2) @(negedge clk);
        n_tests++; if (hi !== 32'd0) begin n_fail++; $display("FAIL reset_hi got %h want 0", hi); end
        n_tests++; if (lo !== 32'd0) begin n_fail++; $display("FAIL reset_lo got %h want 0", lo); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
        reset = 1'b0; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        #1;
        n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b want 0", stall); end
    endtask

    task automatic test_directed();
        logic [1:0]  t_op[7] = '{2'd1, 2'd0, 2'd2, 2'd3, 2'd3, 2'd2, 2'd2};
        logic [31:0] t_a[7]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'd100, 32'd5, 32'h8000_0000, 32'hFFFF_FFF9};
        logic [31:0] t_b[7]  = '{32'hFFFF_FFFF, 32'd7, 32'd2, 32'd7, 32'd0, 32'hFFFF_FFFF, 32'd0};
        logic [31:0] t_hi[7] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd5, 32'd0, 32'hFFFF_FFF9};
        logic [31:0] t_lo[7] = '{32'h0000_0001, 32'hFFFF_FFEB, 32'hFFFF_FFFD, 32'd14, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
        logic [31:0] rhi, rlo, pre;
        int dc, bc;
        logic st0;
        for (int i = 0; i < 7; i++) begin
            run_op(t_op[i], t_a[i], t_b[i], 1'b0, 1'b0, -1, -1, rhi, rlo, pre, dc, bc, st0);
            n_tests++; if (rhi !== t_hi[i]) begin n_fail++; $display("FAIL directed%0d_hi got %h want %h", i, rhi, t_hi[i]); end
            n_tests++; if (rlo !== t_lo[i]) begin n_fail++; $display("FAIL directed%0d_lo got %h want %h", i, rlo, t_lo[i]); end
            n_tests++; if (dc !== 34) begin n_fail++; $display("FAIL directed%0d_latency got %0d want 34", i, dc); end
            n_tests++; if (bc !== 33) begin n_fail++; $display("FAIL directed%0d_busy_cycles got %0d want 33", i, bc); end
            n_tests++; if (st0 !== 1'b1) begin n_fail++; $display("FAIL directed%0d_stall_at_start got %b want 1", i, st0); end
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b, rhi, rlo, pre;
        logic [1:0]  o;
        logic [63:0] exp;
        int dc, bc;
        logic st0;
        for (int i = 0; i < 24; i++) begin
            o = 2'($urandom); a = pick(); b = pick();
            exp = model(o, a, b);
            run_op(o, a, b, 1'b0, 1'b0, -1, -1, rhi, rlo, pre, dc, bc, st0);
            n_tests++; if ({rhi, rlo} !== exp) begin n_fail++;
                $display("FAIL random op%0d %h,%h got %h_%h want %h", o, a, b, rhi, rlo, exp); end
            n_tests++; if (dc !== 34) begin n_fail++; $display("FAIL random_latency got %0d want 34", dc); end
        end
    endtask

    task automatic test_mthi();
        logic [31:0] rhi, rlo, pre;
        logic [63:0] exp;
        int dc, bc;
        logic st0;
        @(negedge clk); hi_we = 1'b1; wdata = 32'h0000_1234;
        @(negedge clk); hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h0000_ABCD;
        n_tests++; if (hi !== 32'h1234) begin n_fail++; $display("FAIL mthi got %h want 00001234", hi); end
        @(negedge clk); lo_we = 1'b0;
        n_tests++; if (lo !== 32'hABCD) begin n_fail++; $display("FAIL mtlo got %h want 0000abcd", lo); end
        n_tests++; if (hi !== 32'h1234) begin n_fail++; $display("FAIL mtlo_hi_hold got %h want 00001234", hi); end
        exp = model(2'd0, 32'hFFFF_0123, 32'h0000_4567);
        run_op(2'd0, 32'hFFFF_0123, 32'h0000_4567, 1'b0, 1'b1, 10, 5, rhi, rlo, pre, dc, bc, st0);
        n_tests++; if (pre !== 32'h1234) begin n_fail++; $display("FAIL mthi_while_busy hi got %h want 00001234", pre); end
        n_tests++; if ({rhi, rlo} !== exp) begin n_fail++; $display("FAIL mthi_product got %h_%h want %h", rhi, rlo, exp); end
        n_tests++; if (dc !== 34) begin n_fail++; $display("FAIL mthi_latency got %0d want 34", dc); end
        repeat (3) @(negedge clk);
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ignored_start busy got %b want 0", busy); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rhi, rlo, pre;
        int dc, bc, seen;
        logic st0;
        @(negedge clk); start = 1'b1; op = 2'd2; rs_val = 32'd1000; rt_val = 32'd7;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (n == 20) reset = 1'b1;
        end
        @(negedge clk); reset = 1'b0;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy got %b want 0", busy); end
        n_tests++; if (hi !== 32'd0) begin n_fail++; $display("FAIL midreset_hi got %h want 0", hi); end
        n_tests++; if (lo !== 32'd0) begin n_fail++; $display("FAIL midreset_lo got %h want 0", lo); end
        seen = 0;
        for (int n = 0; n < 40; n++) begin
            if (done) seen++;
            @(negedge clk);
        end
        n_tests++; if (seen !== 0) begin n_fail++; $display("FAIL midreset_done_pulses got %0d want 0", seen); end
        run_op(2'd3, 32'd1000, 32'd7, 1'b0, 1'b0, -1, -1, rhi, rlo, pre, dc, bc, st0);
        n_tests++; if (rlo !== 32'd142 || rhi !== 32'd6) begin n_fail++;
            $display("FAIL midreset_fresh got %h_%h want 00000006_0000008e", rhi, rlo); end
        n_tests++; if (dc !== 34) begin n_fail++; $display("FAIL midreset_fresh_latency got %0d want 34", dc); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rhi, rlo, pre;
        logic [63:0] exp;
        int dc, bc;
        logic st0;
        exp = model(2'd1, 32'h1234_5678, 32'h9ABC_DEF0);
        run_op(2'd1, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0, -1, -1, rhi, rlo, pre, dc, bc, st0);
        n_tests++; if ({rhi, rlo} !== exp) begin n_fail++; $display("FAIL b2b_first got %h_%h want %h", rhi, rlo, exp); end
        exp = model(2'd2, 32'h8765_4321, 32'h0000_0123);
        run_op(2'd2, 32'h8765_4321, 32'h0000_0123, 1'b1, 1'b0, -1, -1, rhi, rlo, pre, dc, bc, st0);
        n_tests++; if (st0 !== 1'b1) begin n_fail++; $display("FAIL b2b_stall got %b want 1", st0); end
        n_tests++; if ({rhi, rlo} !== exp) begin n_fail++; $display("FAIL b2b_second got %h_%h want %h", rhi, rlo, exp); end
        n_tests++; if (dc !== 34) begin n_fail++; $display("FAIL b2b_latency got %0d want 34", dc); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_mthi();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/ex_muldiv.md
EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001: clk  input  1  single clock; all state updates on its rising edge.
REQ-002: reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-003: start  input  1  request a new operation; sampled only in IDLE.
REQ-004: op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-005: rs_val  input  32  operand A / dividend, taken from the ID/EX rdata1 field.
REQ-006: rt_val  input  32  operand B / divisor, taken from the ID/EX rdata2 field.
REQ-007: hi_we, lo_we  input  1 each  MTHI / MTLO write strobes.
REQ-008: wdata  input  32  data for MTHI / MTLO.
REQ-009: hi, lo  output  32 each  architectural HI and LO registers.
REQ-010: busy  output  1  high whenever the state is not IDLE.
REQ-011: stall  output  1  holds IF/ID and ID/EX; combinational, equals busy OR (start AND state==IDLE).
REQ-012: done  output  1  one-cycle pulse marking the cycle in which new hi/lo become valid.

Function
REQ-013: FSM states: IDLE, RUN, FIX.
- IDLE->RUN on start.
- RUN->FIX after 32 iterations.
- FIX->IDLE unconditionally.
REQ-014: Edge T0 (IDLE, start=1) behaviour:
- latch op, sign flags and the absolute values of both operands (absolute value only for signed ops);
- clear the 6-bit iteration counter;
- enter RUN.
REQ-015: Edges T1..T32 each perform one iteration:
- multiply: shift-add into a 64-bit accumulator;
- divide: restoring shift-subtract with a 33-bit partial remainder.
The counter increments each iteration; edge T32 enters FIX.
REQ-016: Edge T33 (FIX) applies sign fix-up, writes hi/lo, sets done=1 for exactly the following cycle, and returns to IDLE.
- Total latency: start to done = 34 cycles.
- A second start may be accepted in the cycle where done=1.
REQ-017: MULT / MULTU result: {hi,lo} = full 64-bit signed / unsigned product of rs_val and rt_val.
REQ-018: DIV result:
- lo = quotient truncated toward zero;
- hi = remainder carrying the sign of the dividend;
- DIVU: unsigned quotient / remainder.
REQ-019: Divide by zero (rt_val=0), no exception raised:
- lo = 0xFFFFFFFF, hi = rs_val;
- applies to both DIV and DIVU;
- latency unchanged.
REQ-020: DIV overflow, 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0x00000000.
REQ-021: start while busy is ignored; operands and op are sampled only at T0 and never re-read during RUN.
REQ-022: hi_we / lo_we write wdata only in IDLE with start=0.
- Ignored while busy or when start=1.
- hi_we and lo_we together write both registers.
REQ-023: hi/lo hold their values except under REQ-016, REQ-022 and reset.

Reset
REQ-024: On reset the block shall force:
- state = IDLE, counter = 0;
- hi = lo = 0x00000000;
- busy = stall-internal = done = 0.
REQ-025: Reset during RUN or FIX abandons the operation: no done pulse, hi/lo = 0 on the next cycle.
REQ-026: reset has priority over start, hi_we and lo_we in the same cycle.

Verification
REQ-027: MULTU 0xFFFFFFFF x 0xFFFFFFFF -> done at start+34, hi=0xFFFFFFFE, lo=0x00000001; busy high for 33 cycles.
REQ-028: MULT 0xFFFFFFFD (-3) x 7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
REQ-029: DIV -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 100 / 7 -> lo=14, hi=2.
REQ-030: DIVU 5 / 0 -> lo=0xFFFFFFFF, hi=5; DIV 0x80000000 / -1 -> lo=0x80000000, hi=0.
REQ-031: MTHI 0x1234 in IDLE, then start MULT with hi_we pulsed at T10 -> hi=0x1234 before done, product afterwards; second start at T5 ignored.
REQ-032: reset asserted at T20 of a DIV -> next cycle state IDLE, hi=lo=0, busy=0, no done pulse; a fresh start then completes normally.
